// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcodes and shifter mode type for the execute-stage ALU
package alu_pkg;
  localparam int WIDTH = 32;
  localparam int CW = 4;
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_COMP  = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SHLLV = 4'b0100;
  localparam logic [3:0] OP_SHRLV = 4'b0101;
  localparam logic [3:0] OP_SHRAV = 4'b0110;
  localparam logic [3:0] OP_B     = 4'b1000;
  localparam logic [3:0] OP_BL    = 4'b1001;
  localparam logic [3:0] OP_BCY   = 4'b1010;
  localparam logic [3:0] OP_BNCY  = 4'b1011;
  localparam logic [3:0] OP_BR    = 4'b1100;
  localparam logic [3:0] OP_BLTZ  = 4'b1101;
  localparam logic [3:0] OP_BZ    = 4'b1110;
  localparam logic [3:0] OP_BNZ   = 4'b1111;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} sh_mode_t;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational barrel shifter (logical left, logical right, arithmetic right)
module alu_shifter
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0]         data,
  input  logic [$clog2(W)-1:0] amt,
  input  sh_mode_t             mode,
  output logic [W-1:0]         res
);
  logic [W-1:0] sra;
  // kept separate so the mixed-sign ternary below cannot turn >>> into a logical shift
  assign sra = $signed(data) >>> amt;
  assign res = mode == SH_LL ? data << amt : mode == SH_RA ? sra : data >> amt;
endmodule

// File: rtl/alu.sv
// alu: 32-bit registered ALU with branch-condition evaluation and a carry flag written by add
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int CW = alu_pkg::CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CW-1:0]    ALUc,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] ALUresult,
  output logic             b,
  output logic             cy
);
  logic [WIDTH:0] sum;
  logic [WIDTH-1:0] sh, r_nxt;
  logic b_nxt;
  sh_mode_t mode;
  assign sum = {1'b0, data1} + {1'b0, data2};
  assign mode = ALUc == OP_SHLLV ? SH_LL : ALUc == OP_SHRAV ? SH_RA : SH_RL;
  alu_shifter #(.W(WIDTH)) u_sh (.data(data1), .amt(data2[$clog2(WIDTH)-1:0]), .mode(mode), .res(sh));
  always_comb begin
    r_nxt = '0;
    b_nxt = 1'b0;
    case (ALUc)
      OP_ADD:                     r_nxt = sum[WIDTH-1:0];
      OP_COMP:                    r_nxt = ~data2 + 1'b1;
      OP_AND:                     r_nxt = data1 & data2;
      OP_XOR:                     r_nxt = data1 ^ data2;
      OP_SHLLV, OP_SHRLV, OP_SHRAV: r_nxt = sh;
      OP_B, OP_BL, OP_BR:         begin r_nxt = data1; b_nxt = 1'b1; end
      OP_BCY:                     begin r_nxt = data1; b_nxt = cy; end
      OP_BNCY:                    begin r_nxt = data1; b_nxt = ~cy; end
      OP_BLTZ:                    begin r_nxt = data1; b_nxt = data1[WIDTH-1]; end
      OP_BZ:                      begin r_nxt = data1; b_nxt = data1 == '0; end
      OP_BNZ:                     begin r_nxt = data1; b_nxt = data1 != '0; end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ALUresult <= '0;
      b <= 1'b0;
      cy <= 1'b0;
    end else begin
      ALUresult <= r_nxt;
      b <= b_nxt;
      if (ALUc == OP_ADD) cy <= sum[WIDTH];
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu with hand-computed expected values
module tb_alu;
  import alu_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] ALUc = '0;
  logic [31:0] data1 = '0, data2 = '0, ALUresult;
  logic b, cy;
  int checks = 0, errors = 0;
  alu dut (.clk(clk), .rst(rst), .ALUc(ALUc), .data1(data1), .data2(data2), .ALUresult(ALUresult), .b(b), .cy(cy));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [31:0] er, input logic eb, input logic ecy);
    @(negedge clk);
    ALUc = op;
    data1 = d1;
    data2 = d2;
    @(posedge clk);
    #1;
    chk({tag, ".r"}, ALUresult, er);
    chk({tag, ".b"}, {31'b0, b}, {31'b0, eb});
    chk({tag, ".cy"}, {31'b0, cy}, {31'b0, ecy});
  endtask
  initial begin
    #12;
    chk("rst.r", ALUresult, 32'h0);
    chk("rst.b", {31'b0, b}, 32'h0);
    chk("rst.cy", {31'b0, cy}, 32'h0);
    @(negedge clk) rst = 1'b0;
    step("add1", OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    step("addc", OP_ADD, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 1'b1);
    step("comp", OP_COMP, 32'd9, 32'd6, 32'hFFFFFFFA, 1'b0, 1'b1);
    step("and", OP_AND, 32'd12, 32'd23, 32'd4, 1'b0, 1'b1);
    step("xor", OP_XOR, 32'd12, 32'd20, 32'd24, 1'b0, 1'b1);
    step("sll", OP_SHLLV, 32'd1, 32'd2, 32'd4, 1'b0, 1'b1);
    step("srl", OP_SHRLV, 32'hFFFFFFFF, 32'd2, 32'h3FFFFFFF, 1'b0, 1'b1);
    step("sra", OP_SHRAV, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 1'b1);
    step("sra8", OP_SHRAV, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b1);
    step("sra+", OP_SHRAV, 32'h40000000, 32'd4, 32'h04000000, 1'b0, 1'b1);
    step("sll34", OP_SHLLV, 32'd1, 32'd34, 32'd4, 1'b0, 1'b1);
    step("srl0", OP_SHRLV, 32'h00001234, 32'h00000020, 32'h00001234, 1'b0, 1'b1);
    step("rsvd", 4'b0111, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1);
    step("br", OP_BR, 32'd12, 32'd0, 32'd12, 1'b1, 1'b1);
    step("bltz-", OP_BLTZ, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b1);
    step("bltz+", OP_BLTZ, 32'd5, 32'd0, 32'd5, 1'b0, 1'b1);
    step("bz0", OP_BZ, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    step("bz2", OP_BZ, 32'd2, 32'd0, 32'd2, 1'b0, 1'b1);
    step("bnz-", OP_BNZ, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b1);
    step("bnz0", OP_BNZ, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step("b", OP_B, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b1);
    step("bl", OP_BL, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b1);
    step("bcy1", OP_BCY, 32'd8, 32'd0, 32'd8, 1'b1, 1'b1);
    step("bncy1", OP_BNCY, 32'd8, 32'd0, 32'd8, 1'b0, 1'b1);
    step("add2", OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    step("bcy0", OP_BCY, 32'd8, 32'd0, 32'd8, 1'b0, 1'b0);
    step("bncy0", OP_BNCY, 32'd8, 32'd0, 32'd8, 1'b1, 1'b0);
    step("addc2", OP_ADD, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, 1'b1);
    step("bcyimm", OP_BCY, 32'd3, 32'd0, 32'd3, 1'b1, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("arst.r", ALUresult, 32'h0);
    chk("arst.b", {31'b0, b}, 32'h0);
    chk("arst.cy", {31'b0, cy}, 32'h0);
    @(negedge clk) rst = 1'b0;
    step("add56", OP_ADD, 32'd5, 32'd6, 32'd11, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
